// File: rtl/rr_arbiter8.sv
// 8-client round-robin arbiter with registered one-hot grant, owner index,
// and an optional per-owner hold limit that forces release with a timeout pulse.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit         HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

    state_t     state_q, state_d;
    logic [2:0] last_q, last_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;
    logic       to_q, to_d;
    logic       found;
    logic [2:0] winner;

    // Offsets are scanned from farthest to nearest so the nearest requester
    // after last wins; offset 8 wraps to last itself, the lowest priority.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
        logic [3:0] res;
        logic [2:0] c;
        res = 4'b0;
        for (int i = 8; i >= 1; i--) begin
            c = last + 3'(i);
            if (r[c]) res = {1'b1, c};
        end
        return res;
    endfunction

    function automatic logic [7:0] decode3to8(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

    assign {found, winner} = rr_pick(req, last_q);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && found) begin
                    state_d = GRANT;
                    idx_d   = winner;
                    valid_d = 1'b1;
                    hold_d  = 8'd0;
                end
            end
            GRANT: begin
                // A voluntary drop takes precedence over the hold limit.
                if (!req[idx_q]) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = idx_q;
                end else if (HOLD_EN && (hold_q == HOLD_LAST)) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = idx_q;
                    to_d    = 1'b1;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_d = valid_d ? decode3to8(idx_d) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 3'd7;
            idx_q   <= 3'd0;
            hold_q  <= 8'd0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
            gnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            to_q    <= to_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = to_q;

endmodule
